// File: rtl/eth_mac_tx_framer.sv
// -----------------------------------------------------------------------------
// eth_mac_tx_framer
//
// GMII transmit framer for Ethernet II frames. For each accepted request it
// emits the preamble and SFD, the 14-byte header (destination MAC, SRC_MAC,
// EtherType), the streamed payload, zero padding up to MIN_PAYLOAD and the
// 4-byte FCS. It then holds the line idle for IFG_BYTES cycles. The FCS comes
// from an external byte-wide CRC-32 block that this module feeds through
// crc_d/crc_en/crc_clr and reads back through crc_data.
//
// Ports:
//   clk, rst_n            GMII TX clock (125 MHz), async active-low reset
//   tx_start              one-cycle frame request, sampled only in IDLE
//   tx_dst_mac            destination MAC, latched on an accepted tx_start
//   tx_eth_type           EtherType, latched on an accepted tx_start
//   tx_len                payload byte count, clamped to MAX_PAYLOAD
//   tx_busy               high from the cycle after acceptance through the last IFG cycle
//   tx_done / tx_err      one-cycle pulses: normal end / payload underrun
//   s_tdata/s_tvalid/s_tready  payload byte stream (consumed when valid & ready)
//   crc_d/crc_en/crc_clr  combinational controls to the CRC block
//   crc_data              registered CRC value from the CRC block
//   gmii_tx_en/tx_er/txd  registered GMII transmit outputs
// -----------------------------------------------------------------------------
module eth_mac_tx_framer #(
    parameter logic [47:0] SRC_MAC     = 48'h00_0A_35_01_FE_C0,
    parameter int          MIN_PAYLOAD = 46,
    parameter int          MAX_PAYLOAD = 1500,
    parameter int          IFG_BYTES   = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_start,
    input  logic [47:0] tx_dst_mac,
    input  logic [15:0] tx_eth_type,
    input  logic [10:0] tx_len,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        tx_err,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [7:0]  crc_d,
    output logic        crc_en,
    output logic        crc_clr,
    input  logic [31:0] crc_data,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic [7:0]  gmii_txd
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_PAY,
        S_PAD,
        S_FCS,
        S_IFG
    } state_t;

    localparam logic [10:0] MAX_LEN  = 11'(MAX_PAYLOAD);
    localparam logic [10:0] MIN_LEN  = 11'(MIN_PAYLOAD);
    localparam logic [10:0] IFG_LAST = 11'(IFG_BYTES - 1);

    state_t       state;
    logic [10:0]  cnt;        // byte index within the current state
    logic [10:0]  len_q;      // clamped payload length of the frame in flight
    logic [10:0]  pad_q;      // number of zero pad bytes after the payload
    logic [111:0] hdr_sr;     // header bytes, shifted out MSB first
    logic         abort_q;    // frame ended by underrun (selects tx_err over tx_done)

    logic [10:0]  len_clamped;
    logic [10:0]  pad_calc;

    logic [7:0]   sel_byte;
    logic         sel_en;
    logic         sel_er;

    // FCS byte k is the complemented CRC byte k, bit-reversed, because the
    // CRC block presents its register in the opposite bit order to the wire.
    function automatic logic [7:0] fcs_byte(input logic [31:0] c, input logic [1:0] k);
        logic [7:0] b;
        logic [7:0] r;
        b = c[{k, 3'b000} +: 8];
        for (int j = 0; j < 8; j++) begin
            r[j] = ~b[7 - j];
        end
        return r;
    endfunction

    assign len_clamped = (tx_len > MAX_LEN) ? MAX_LEN : tx_len;
    assign pad_calc    = (len_clamped < MIN_LEN) ? (MIN_LEN - len_clamped) : 11'd0;

    // Byte selection for the current state; it lands on GMII one cycle later.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        sel_byte = 8'h00;
        sel_en   = 1'b0;
        sel_er   = 1'b0;
        crc_en   = 1'b0;
        crc_clr  = 1'b0;
        s_tready = 1'b0;
        case (state)
            S_IDLE: crc_clr = 1'b1;
            S_PRE: begin
                sel_en   = 1'b1;
                sel_byte = (cnt == 11'd7) ? 8'hD5 : 8'h55;
            end
            S_HDR: begin
                sel_en   = 1'b1;
                sel_byte = hdr_sr[111:104];
                crc_en   = 1'b1;
            end
            S_PAY: begin
                s_tready = 1'b1;
                sel_en   = 1'b1;
                if (s_tvalid) begin
                    sel_byte = s_tdata;
                    crc_en   = 1'b1;
                end else begin
                    // Underrun: one 0x00 byte flagged with TX_ER, then abort.
                    sel_er = 1'b1;
                end
            end
            S_PAD: begin
                sel_en = 1'b1;
                crc_en = 1'b1;
            end
            S_FCS: begin
                sel_en   = 1'b1;
                sel_byte = fcs_byte(crc_data, cnt[1:0]);
            end
            default: ;
        endcase
        crc_d = sel_byte;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            len_q      <= '0;
            pad_q      <= '0;
            hdr_sr     <= '0;
            abort_q    <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            tx_err     <= 1'b0;
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
            gmii_txd   <= '0;
        end else begin
            gmii_txd   <= sel_byte;
            gmii_tx_en <= sel_en;
            gmii_tx_er <= sel_er;
            tx_done    <= 1'b0;
            tx_err     <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (tx_start) begin
                        state   <= S_PRE;
                        cnt     <= '0;
                        tx_busy <= 1'b1;
                        len_q   <= len_clamped;
                        pad_q   <= pad_calc;
                        hdr_sr  <= {tx_dst_mac, SRC_MAC, tx_eth_type};
                        abort_q <= 1'b0;
                    end
                end
                S_PRE: begin
                    if (cnt == 11'd7) begin
                        state <= S_HDR;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end
                S_HDR: begin
                    hdr_sr <= hdr_sr << 8;
                    if (cnt == 11'd13) begin
                        cnt <= '0;
                        if (len_q != 11'd0)      state <= S_PAY;
                        else if (pad_q != 11'd0) state <= S_PAD;
                        else                     state <= S_FCS;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end
                S_PAY: begin
                    if (!s_tvalid) begin
                        state   <= S_IFG;
                        cnt     <= '0;
                        abort_q <= 1'b1;
                    end else if (cnt == len_q - 11'd1) begin
                        cnt   <= '0;
                        state <= (pad_q != 11'd0) ? S_PAD : S_FCS;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end
                S_PAD: begin
                    if (cnt == pad_q - 11'd1) begin
                        state <= S_FCS;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end
                S_FCS: begin
                    if (cnt == 11'd3) begin
                        state <= S_IFG;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end
                S_IFG: begin
                    // First IFG cycle is when gmii_tx_en is registered low,
                    // so the end-of-frame pulse lines up with the drop.
                    if (cnt == 11'd0) begin
                        tx_done <= ~abort_q;
                        tx_err  <= abort_q;
                    end
                    if (cnt == IFG_LAST) begin
                        state   <= S_IDLE;
                        cnt     <= '0;
                        tx_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_mac_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_eth_mac_tx_framer
//
// Directed bench for eth_mac_tx_framer. Includes a behavioural byte-wide
// CRC-32 block (reflected algorithm, register presented per-byte bit-reversed
// on crc_data), a payload source, and a GMII monitor. Expected frames are
// built from the bench's own payload tables and a reference CRC-32.
// -----------------------------------------------------------------------------
module tb_eth_mac_tx_framer;

    localparam logic [47:0] SRC_MAC = 48'h00_0A_35_01_FE_C0;
    localparam logic [47:0] BCAST   = 48'hFF_FF_FF_FF_FF_FF;

    logic        clk;
    logic        rst_n;
    logic        tx_start;
    logic [47:0] tx_dst_mac;
    logic [15:0] tx_eth_type;
    logic [10:0] tx_len;
    logic        tx_busy, tx_done, tx_err;
    logic [7:0]  s_tdata;
    logic        s_tvalid, s_tready;
    logic [7:0]  crc_d;
    logic        crc_en, crc_clr;
    logic [31:0] crc_data;
    logic        gmii_tx_en, gmii_tx_er;
    logic [7:0]  gmii_txd;

    int checks   = 0;
    int failures = 0;

    eth_mac_tx_framer #(
        .SRC_MAC(SRC_MAC), .MIN_PAYLOAD(46), .MAX_PAYLOAD(1500), .IFG_BYTES(12)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_dst_mac(tx_dst_mac),
        .tx_eth_type(tx_eth_type), .tx_len(tx_len), .tx_busy(tx_busy),
        .tx_done(tx_done), .tx_err(tx_err), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tready(s_tready), .crc_d(crc_d), .crc_en(crc_en), .crc_clr(crc_clr),
        .crc_data(crc_data), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
        .gmii_txd(gmii_txd)
    );

    initial begin
        clk = 1'b0;
        forever #4 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- CRC-32 block model ----------------
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [31:0] byte_rev(input logic [31:0] c);
        logic [31:0] r;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 8; j++) r[8*k + 7 - j] = c[8*k + j];
        return r;
    endfunction

    logic [31:0] crc_reg;
    always @(posedge clk) begin
        if (crc_clr)     crc_reg <= 32'hFFFF_FFFF;
        else if (crc_en) crc_reg <= crc_step(crc_reg, crc_d);
    end
    assign crc_data = byte_rev(crc_reg);

    // ---------------- payload source ----------------
    logic [7:0] pay_mem [0:2047];
    int   consumed = 0;
    int   drop_at  = -1;     // index at which s_tvalid is withheld (-1: never)

    initial begin
        bit hs;
        s_tvalid = 1'b0;
        s_tdata  = 8'h00;
        forever begin
            @(negedge clk);
            hs = s_tvalid && s_tready && rst_n;
            @(posedge clk);
            #1;
            if (hs) consumed++;
            s_tdata  = pay_mem[consumed % 2048];
            s_tvalid = !(drop_at >= 0 && consumed == drop_at);
        end
    end

    // ---------------- GMII monitor ----------------
    logic [7:0] rx[$];
    logic [7:0] exp_q[$];
    int gaps[$];
    int en_cycles, rises, low_run, first_rise_cyc, fall_cyc;
    int done_count, err_count, done_cyc, err_cyc, er_count, er_idx, tready_count;
    int start_cyc;
    logic prev_en = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en = 1'b0;
        end else begin
            if (gmii_tx_en) begin
                if (!prev_en) begin
                    if (rises > 0) gaps.push_back(low_run);
                    rises++;
                    if (rises == 1) first_rise_cyc = cyc;
                end
                if (gmii_tx_er) begin
                    er_count++;
                    er_idx = rx.size();
                end
                rx.push_back(gmii_txd);
                en_cycles++;
                low_run = 0;
            end else begin
                if (prev_en) fall_cyc = cyc;
                if (rises > 0) low_run++;
                if (gmii_tx_er) er_count++;
            end
            if (tx_done) begin done_count++; done_cyc = cyc; end
            if (tx_err)  begin err_count++;  err_cyc  = cyc; end
            if (s_tready) tready_count++;
            prev_en = gmii_tx_en;
        end
    end

    task automatic clear_mon();
        rx.delete(); gaps.delete();
        en_cycles = 0; rises = 0; low_run = 0; first_rise_cyc = -1; fall_cyc = -1;
        done_count = 0; err_count = 0; done_cyc = -1; err_cyc = -2;
        er_count = 0; er_idx = -1; tready_count = 0;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic start_frame(input logic [47:0] dst, input logic [15:0] typ, input logic [10:0] len);
        @(negedge clk);
        tx_dst_mac = dst; tx_eth_type = typ; tx_len = len; tx_start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_end(input int n, input int budget, input string name);
        int k = 0;
        while (!((done_count + err_count) >= n && !tx_busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!((done_count + err_count) >= n && !tx_busy)) begin
            checks++; failures++;
            $display("FAIL %s_timeout: frame did not finish within %0d cycles", name, budget);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic build_exp(input logic [47:0] dst, input logic [15:0] typ, input int len);
        int n;
        logic [31:0] c;
        logic [111:0] hdr;
        n = (len > 1500) ? 1500 : len;
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        hdr = {dst, SRC_MAC, typ};
        for (int i = 0; i < 14; i++) exp_q.push_back(hdr[111 - 8*i -: 8]);
        for (int i = 0; i < n; i++) exp_q.push_back(pay_mem[i]);
        for (int i = n; i < 46; i++) exp_q.push_back(8'h00);
        c = 32'hFFFF_FFFF;
        for (int i = 8; i < exp_q.size(); i++) c = crc_step(c, exp_q[i]);
        c = ~c;
        exp_q.push_back(c[7:0]); exp_q.push_back(c[15:8]);
        exp_q.push_back(c[23:16]); exp_q.push_back(c[31:24]);
    endtask

    // -1: identical, -2: length differs, else index of first differing byte
    function automatic int frame_diff();
        if (rx.size() != exp_q.size()) return -2;
        foreach (exp_q[i]) if (rx[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({gmii_tx_en, gmii_tx_er, gmii_txd} !== 10'd0) begin
            failures++;
            $display("FAIL reset_gmii: en=%b er=%b txd=%h, want all 0", gmii_tx_en, gmii_tx_er, gmii_txd);
        end
        checks++;
        if ({tx_busy, tx_done, tx_err, s_tready, crc_en} !== 5'd0) begin
            failures++;
            $display("FAIL reset_status: busy=%b done=%b err=%b tready=%b crc_en=%b, want all 0",
                     tx_busy, tx_done, tx_err, s_tready, crc_en);
        end
        checks++;
        if (crc_clr !== 1'b1) begin
            failures++;
            $display("FAIL reset_crc_clr: got %b want 1", crc_clr);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_len46();
        int d;
        for (int i = 0; i < 2048; i++) pay_mem[i] = 8'(i);
        consumed = 0; drop_at = -1;
        clear_mon();
        start_frame(BCAST, 16'h0800, 11'd46);
        wait_end(1, 400, "len46");
        build_exp(BCAST, 16'h0800, 46);
        d = frame_diff();
        checks++;
        if (d !== -1) begin
            failures++;
            $display("FAIL len46_bytes: diff at %0d (rx size %0d, want size %0d)", d, rx.size(), exp_q.size());
        end
        checks++;
        if (en_cycles !== 72) begin failures++; $display("FAIL len46_en_cycles: got %0d want 72", en_cycles); end
        checks++;
        if (first_rise_cyc - start_cyc !== 2) begin
            failures++;
            $display("FAIL len46_latency: got %0d want 2", first_rise_cyc - start_cyc);
        end
        checks++;
        if (done_count !== 1 || done_cyc !== fall_cyc) begin
            failures++;
            $display("FAIL len46_done: count %0d at cyc %0d, want 1 at fall cyc %0d", done_count, done_cyc, fall_cyc);
        end
        checks++;
        if (consumed !== 46 || err_count !== 0 || er_count !== 0) begin
            failures++;
            $display("FAIL len46_stream: consumed %0d err %0d er %0d, want 46 0 0", consumed, err_count, er_count);
        end
    endtask

    task automatic test_len0();
        int d;
        consumed = 0;
        clear_mon();
        start_frame(48'h02_11_22_33_44_55, 16'h88B5, 11'd0);
        wait_end(1, 400, "len0");
        build_exp(48'h02_11_22_33_44_55, 16'h88B5, 0);
        d = frame_diff();
        checks++;
        if (d !== -1) begin failures++; $display("FAIL len0_bytes: diff at %0d (rx size %0d)", d, rx.size()); end
        checks++;
        if (en_cycles !== 72) begin failures++; $display("FAIL len0_en_cycles: got %0d want 72", en_cycles); end
        checks++;
        if (tready_count !== 0 || done_count !== 1) begin
            failures++;
            $display("FAIL len0_tready: tready cycles %0d done %0d, want 0 1", tready_count, done_count);
        end
    endtask

    task automatic test_len10();
        int d;
        for (int i = 0; i < 2048; i++) pay_mem[i] = 8'hA0 + 8'(i);
        consumed = 0;
        clear_mon();
        start_frame(48'h00_1B_21_3C_4D_5E, 16'h86DD, 11'd10);
        wait_end(1, 400, "len10");
        build_exp(48'h00_1B_21_3C_4D_5E, 16'h86DD, 10);
        d = frame_diff();
        checks++;
        if (d !== -1) begin failures++; $display("FAIL len10_bytes: diff at %0d (rx size %0d)", d, rx.size()); end
        checks++;
        if (consumed !== 10 || en_cycles !== 72) begin
            failures++;
            $display("FAIL len10_counts: consumed %0d en %0d, want 10 72", consumed, en_cycles);
        end
    endtask

    task automatic test_clamp();
        int d;
        for (int i = 0; i < 2048; i++) pay_mem[i] = 8'(i) ^ 8'h5A;
        consumed = 0;
        clear_mon();
        start_frame(48'h00_AA_BB_CC_DD_EE, 16'h0806, 11'd1600);
        wait_end(1, 3000, "clamp");
        build_exp(48'h00_AA_BB_CC_DD_EE, 16'h0806, 1600);
        d = frame_diff();
        checks++;
        if (d !== -1) begin failures++; $display("FAIL clamp_bytes: diff at %0d (rx size %0d)", d, rx.size()); end
        checks++;
        if (consumed !== 1500) begin failures++; $display("FAIL clamp_consumed: got %0d want 1500", consumed); end
        checks++;
        if (en_cycles !== 1526) begin failures++; $display("FAIL clamp_en_cycles: got %0d want 1526", en_cycles); end
    endtask

    task automatic test_underrun();
        int d;
        int k;
        for (int i = 0; i < 2048; i++) pay_mem[i] = 8'h10 + 8'(i);
        consumed = 0; drop_at = 5;
        clear_mon();
        start_frame(48'h00_01_02_03_04_05, 16'h0800, 11'd60);
        k = 0;
        while (err_count == 0 && k < 400) begin @(negedge clk); k++; end
        build_exp(48'h00_01_02_03_04_05, 16'h0800, 60);
        while (exp_q.size() > 27) void'(exp_q.pop_back());
        exp_q.push_back(8'h00);
        d = frame_diff();
        checks++;
        if (d !== -1) begin failures++; $display("FAIL underrun_bytes: diff at %0d (rx size %0d want 28)", d, rx.size()); end
        checks++;
        if (er_count !== 1 || er_idx !== 27) begin
            failures++;
            $display("FAIL underrun_er: er cycles %0d at byte %0d, want 1 at 27", er_count, er_idx);
        end
        checks++;
        if (err_count !== 1 || err_cyc !== fall_cyc || done_count !== 0) begin
            failures++;
            $display("FAIL underrun_pulse: err %0d at %0d fall %0d done %0d, want 1 at fall, done 0",
                     err_count, err_cyc, fall_cyc, done_count);
        end
        // Request the next frame straight away; it must wait out the IFG.
        drop_at = -1; consumed = 0;
        tx_dst_mac = BCAST; tx_eth_type = 16'h0800; tx_len = 11'd10; tx_start = 1'b1;
        k = 0;
        while (rises < 2 && k < 200) begin @(negedge clk); k++; end
        tx_start = 1'b0;
        wait_end(2, 400, "underrun");
        checks++;
        if (gaps.size() !== 1 || gaps[0] !== 13) begin
            failures++;
            $display("FAIL underrun_ifg: %0d gaps, first %0d, want 1 gap of 13", gaps.size(), gaps.size() > 0 ? gaps[0] : -1);
        end
        checks++;
        if (done_count !== 1 || err_count !== 1) begin
            failures++;
            $display("FAIL underrun_next: done %0d err %0d, want 1 1", done_count, err_count);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        int bad;
        consumed = 0;
        clear_mon();
        @(negedge clk);
        tx_dst_mac = BCAST; tx_eth_type = 16'h0800; tx_len = 11'd0; tx_start = 1'b1;
        k = 0;
        while (rises < 3 && k < 600) begin @(negedge clk); k++; end
        tx_start = 1'b0;
        wait_end(3, 400, "b2b");
        bad = 0;
        foreach (gaps[i]) if (gaps[i] !== 13) bad++;
        checks++;
        if (gaps.size() !== 2 || bad !== 0) begin
            failures++;
            $display("FAIL b2b_gaps: %0d gaps, %0d not 13, want 2 gaps of 13", gaps.size(), bad);
        end
        checks++;
        if (en_cycles !== 216 || done_count !== 3) begin
            failures++;
            $display("FAIL b2b_frames: en %0d done %0d, want 216 3", en_cycles, done_count);
        end
    endtask

    task automatic test_mid_start_ignored();
        int d;
        int k;
        for (int i = 0; i < 2048; i++) pay_mem[i] = 8'hC3 ^ 8'(i);
        consumed = 0;
        clear_mon();
        start_frame(48'h00_50_C2_00_00_01, 16'h1234, 11'd20);
        k = 0;
        while (rises < 1 && k < 50) begin @(negedge clk); k++; end
        repeat (10) @(negedge clk);
        tx_dst_mac = 48'h11_11_11_11_11_11; tx_eth_type = 16'hBEEF; tx_len = 11'd5; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        k = 0;
        while (done_count == 0 && k < 200) begin @(negedge clk); k++; end
        repeat (3) @(negedge clk);
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        wait_end(1, 200, "midstart");
        repeat (20) @(negedge clk);
        build_exp(48'h00_50_C2_00_00_01, 16'h1234, 20);
        d = frame_diff();
        checks++;
        if (d !== -1) begin failures++; $display("FAIL midstart_bytes: diff at %0d (rx size %0d)", d, rx.size()); end
        checks++;
        if (rises !== 1 || done_count !== 1) begin
            failures++;
            $display("FAIL midstart_frames: frames %0d done %0d, want 1 1", rises, done_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        int d;
        int k;
        for (int i = 0; i < 2048; i++) pay_mem[i] = 8'(3 * i);
        consumed = 0;
        clear_mon();
        start_frame(48'h00_0C_29_AB_CD_EF, 16'h0800, 11'd46);
        k = 0;
        while (rises < 1 && k < 50) begin @(negedge clk); k++; end
        repeat (12) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({gmii_tx_en, gmii_tx_er, gmii_txd, tx_busy} !== 11'd0) begin
            failures++;
            $display("FAIL rstmid_async: en=%b er=%b txd=%h busy=%b, want all 0", gmii_tx_en, gmii_tx_er, gmii_txd, tx_busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_count !== 0 || err_count !== 0) begin
            failures++;
            $display("FAIL rstmid_pulses: done %0d err %0d, want 0 0", done_count, err_count);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        consumed = 0;
        clear_mon();
        start_frame(48'h00_0C_29_AB_CD_EF, 16'h0800, 11'd46);
        wait_end(1, 400, "rstmid");
        build_exp(48'h00_0C_29_AB_CD_EF, 16'h0800, 46);
        d = frame_diff();
        checks++;
        if (d !== -1) begin failures++; $display("FAIL rstmid_bytes: diff at %0d (rx size %0d)", d, rx.size()); end
    endtask

    initial begin
        tx_start = 1'b0; tx_dst_mac = '0; tx_eth_type = '0; tx_len = '0; rst_n = 1'b0;
        for (int i = 0; i < 2048; i++) pay_mem[i] = 8'h00;
        clear_mon();
        test_reset();
        test_len46();
        test_len0();
        test_len10();
        test_clamp();
        test_underrun();
        test_back_to_back();
        test_mid_start_ignored();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eth_mac_tx_framer.md
Name: eth_mac_tx_framer

Overview:
- GMII transmit framer that sits directly upstream of the byte-wide CRC-32 generator instance.
- Builds a complete Ethernet II frame on GMII: preamble, SFD, destination MAC, source MAC, EtherType, streamed payload, zero pad and FCS.
- Drives the CRC block's data, enable and clear inputs, and reads back its registered CRC to emit the 4-byte FCS.
- Enforces the inter-frame gap before accepting the next frame.

Parameters:
SRC_MAC, 48'h00_0A_35_01_FE_C0, source MAC inserted in every frame
MIN_PAYLOAD, 46, minimum payload bytes; shorter payloads are zero-padded up to this
MAX_PAYLOAD, 1500, tx_len values above this are clamped to it
IFG_BYTES, 12, idle cycles after the FCS before the next frame may start

Ports:
clk  in  1  GMII transmit clock, 125 MHz
rst_n  in  1  asynchronous active-low reset
tx_start  in  1  one-cycle frame request; sampled only in IDLE
tx_dst_mac  in  48  destination MAC; latched on accepted tx_start
tx_eth_type  in  16  EtherType; latched on accepted tx_start
tx_len  in  11  payload byte count (0..2047, clamped to MAX_PAYLOAD); latched on accepted tx_start
tx_busy  out  1  high from the cycle after an accepted tx_start through the last IFG cycle
tx_done  out  1  one-cycle pulse when a frame ends normally
tx_err  out  1  one-cycle pulse on payload underrun
s_tdata  in  8  payload byte
s_tvalid  in  1  payload byte valid
s_tready  out  1  payload byte consumed this cycle when s_tvalid and s_tready are both high
crc_d  out  8  byte to the CRC block (combinational)
crc_en  out  1  CRC update enable (combinational)
crc_clr  out  1  CRC reset to FFFFFFFF (combinational)
crc_data  in  32  registered CRC value from the CRC block
gmii_tx_en  out  1  registered GMII TX_EN
gmii_tx_er  out  1  registered GMII TX_ER
gmii_txd  out  8  registered GMII TXD

Behaviour:
- Reset: all registered outputs are 0, state is IDLE, counters are 0. A reset asserted mid-frame drops gmii_tx_en immediately; no FCS and no pulse are emitted.
- Clock/reset: clk and rst_n; reset is asynchronous and active-low.
- Byte emission: each state decides one byte per cycle, which is registered onto gmii_txd the next cycle.
- States and transitions:
  - IDLE: crc_clr is high every IDLE cycle. tx_start moves to PRE; otherwise stay. tx_start in any other state is ignored.
  - PRE: 8 bytes, 7 x 0x55 then 0xD5.
  - HDR: 14 bytes: destination MAC MSB byte first, then SRC_MAC MSB first, then EtherType MSB first.
  - PAY: len bytes. s_tready = 1 in PAY; the consumed s_tdata is emitted next cycle. len = 0 skips PAY.
  - PAD: max(0, MIN_PAYLOAD - len) bytes of 0x00.
  - FCS: 4 bytes.
  - IFG: IFG_BYTES cycles with gmii_tx_en = 0, then return to IDLE.
- CRC coupling:
  - crc_en = 1 and crc_d = the chosen byte in every cycle that selects a byte from HDR, PAY or PAD.
  - crc_en = 0 during PRE, FCS and IFG.
  - FCS byte k (k = 0..3) is driven from crc_data with bit j = ~crc_data[8k+7-j].
  - crc_data is already final when FCS byte 0 is selected, because the last pad/payload byte updated the CRC block in the preceding cycle.
- Latency and duration:
  - gmii_tx_en rises 2 cycles after the accepted tx_start (one cycle IDLE→PRE, one output register).
  - gmii_tx_en stays high for exactly 8 + 14 + max(len, MIN_PAYLOAD) + 4 cycles.
  - tx_done pulses in the first cycle with gmii_tx_en = 0 after the FCS.
  - tx_busy stays high until the last IFG cycle.
- Underrun:
  - Trigger: s_tvalid = 0 in a PAY cycle.
  - Output: the byte emitted next cycle is 0x00 with gmii_tx_er = 1 and gmii_tx_en = 1, for exactly one cycle.
  - Then gmii_tx_en drops, tx_err pulses alongside the drop, no FCS is sent, no tx_done, state goes to IFG.
- Clamp: tx_len > MAX_PAYLOAD sends MAX_PAYLOAD payload bytes.
- Back-to-back: tx_start held high continuously gives frames separated by exactly IFG_BYTES + 1 idle cycles.

Test Plan:
- tx_len = 46, dst FF:FF:FF:FF:FF:FF, type 0x0800, payload 0x00..0x2D, always valid → tx_en high for 72 cycles; bytes 55×7, D5, header, payload; FCS equals standard reflected CRC-32 (init FFFFFFFF, final XOR) of bytes 9..68 sent LSB byte first; tx_done one pulse.
- tx_len = 0 → 46 bytes of 0x00 pad; tx_en high for 72 cycles; s_tready never asserted; FCS matches the reference model.
- tx_len = 10 → 10 payload bytes then 36 pad bytes; tx_len = 1600 → exactly 1500 payload bytes consumed and tx_en high for 1526 cycles.
- Underrun: s_tvalid dropped at payload byte 5 of 60 → one cycle with TXD = 0x00, tx_er = 1; tx_err pulses; no FCS; next frame accepted after 12 IFG cycles.
- tx_start held high continuously and re-pulsed mid-frame → mid-frame pulses ignored; consecutive frames have exactly 13 tx_en-low cycles between them.
- rst_n asserted during HDR → tx_en, tx_er, txd and tx_busy go to 0 asynchronously; after release the next tx_start produces a clean frame with a correct FCS (crc_clr was seen in IDLE).
